// File: rtl/load_arbiter.sv
// Serial frame loader with a one-entry pending buffer, plus an arbiter for the cache
// write port. The processor normally wins the port, but a starvation guard limits how long a frame can wait.
module load_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csi_n,
    input  logic              csd_n,
    input  logic              mosi_in,
    input  logic              bit_en_in,
    input  logic              proc_req_in,
    input  logic              clr_err_in,
    output logic              proc_gnt_out,
    output logic              wr_en_out,
    output logic              wr_sel_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [DATA_W-1:0] wr_data_out,
    output logic              busy_out,
    output logic              overrun_err_out,
    output logic              select_err_out
);
    localparam int FW = ADDR_W + DATA_W;
    localparam int CW = $clog2(FW + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic              tgt_q, tgt_d;
    logic [FW-1:0]     shift_q, shift_d;
    logic [CW-1:0]     bitCnt_q, bitCnt_d;
    logic              pend_q, pend_d;
    logic              pendSel_q, pendSel_d;
    logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
    logic [DATA_W-1:0] pendData_q, pendData_d;
    logic [WW-1:0]     waitCnt_q, waitCnt_d;
    logic              wrEn_q, wrEn_d;
    logic              wrSel_q, wrSel_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic              ovrErr_q, ovrErr_d;
    logic              selErr_q, selErr_d;

    logic          oneSel, bothLow, active, done, issue, waitMax, ovrEvt;
    logic [FW-1:0] frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= 1'b0;
            shift_q    <= '0;
            bitCnt_q   <= '0;
            pend_q     <= 1'b0;
            pendSel_q  <= 1'b0;
            pendAddr_q <= '0;
            pendData_q <= '0;
            waitCnt_q  <= '0;
            wrEn_q     <= 1'b0;
            wrSel_q    <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            ovrErr_q   <= 1'b0;
            selErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            shift_q    <= shift_d;
            bitCnt_q   <= bitCnt_d;
            pend_q     <= pend_d;
            pendSel_q  <= pendSel_d;
            pendAddr_q <= pendAddr_d;
            pendData_q <= pendData_d;
            waitCnt_q  <= waitCnt_d;
            wrEn_q     <= wrEn_d;
            wrSel_q    <= wrSel_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            ovrErr_q   <= ovrErr_d;
            selErr_q   <= selErr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        pend_d     = pend_q;
        pendSel_d  = pendSel_q;
        pendAddr_d = pendAddr_q;
        pendData_d = pendData_q;
        waitCnt_d  = waitCnt_q;
        wrEn_d     = 1'b0;
        wrSel_d    = wrSel_q;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        done       = 1'b0;
        ovrEvt     = 1'b0;

        oneSel  = csi_n ^ csd_n;
        bothLow = ~(csi_n | csd_n);
        frame   = {mosi_in, shift_q[FW-1:1]};

        // A frame in progress continues only while its own select is the single one low.
        if (state_q == IDLE) active = oneSel;
        else                 active = oneSel & (tgt_q ? ~csd_n : ~csi_n);

        if (active) begin
            state_d = SHIFT;
            tgt_d   = ~csd_n;
            if (bit_en_in) begin
                shift_d = frame;
                if (bitCnt_q == CW'(FW - 1)) begin
                    done     = 1'b1;
                    bitCnt_d = '0;
                end else begin
                    bitCnt_d = bitCnt_q + CW'(1);
                end
            end
        end else begin
            state_d  = IDLE;
            shift_d  = '0;
            bitCnt_d = '0;
        end

        waitMax = (waitCnt_q == WW'(MAX_WAIT));
        issue   = pend_q & (~proc_req_in | waitMax);

        if (issue) begin
            wrEn_d    = 1'b1;
            wrSel_d   = pendSel_q;
            wrAddr_d  = pendAddr_q;
            wrData_d  = pendData_q;
            waitCnt_d = '0;
            pend_d    = done;
        end else if (pend_q) begin
            if (!waitMax) waitCnt_d = waitCnt_q + WW'(1);
            ovrEvt = done;
        end else begin
            pend_d = done;
        end

        // The buffer slot is free this edge either because it was empty or because it is draining.
        if (done && !ovrEvt) begin
            pendSel_d  = tgt_d;
            pendAddr_d = frame[ADDR_W-1:0];
            pendData_d = frame[FW-1:ADDR_W];
        end

        if (ovrEvt)          ovrErr_d = 1'b1;
        else if (clr_err_in) ovrErr_d = 1'b0;
        else                 ovrErr_d = ovrErr_q;

        if (bothLow)         selErr_d = 1'b1;
        else if (clr_err_in) selErr_d = 1'b0;
        else                 selErr_d = selErr_q;
    end

    assign proc_gnt_out    = proc_req_in & ~wrEn_q & ~(pend_q & waitMax);
    assign wr_en_out       = wrEn_q;
    assign wr_sel_out      = wrSel_q;
    assign wr_addr_out     = wrAddr_q;
    assign wr_data_out     = wrData_q;
    assign busy_out        = ((state_q == SHIFT) && (bitCnt_q != '0)) | pend_q;
    assign overrun_err_out = ovrErr_q;
    assign select_err_out  = selErr_q;

endmodule

// File: tb/tb_load_arbiter.sv
// Self-checking bench for load_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a frame-level behavioural model.
module tb_load_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int FW = AW + DW;
    localparam int MW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, csi_n, csd_n, mosi_in, bit_en_in, proc_req_in, clr_err_in;
    logic          proc_gnt_out, wr_en_out, wr_sel_out, busy_out;
    logic          overrun_err_out, select_err_out;
    logic [AW-1:0] wr_addr_out;
    logic [DW-1:0] wr_data_out;

    load_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .csi_n(csi_n), .csd_n(csd_n), .mosi_in(mosi_in),
        .bit_en_in(bit_en_in), .proc_req_in(proc_req_in), .clr_err_in(clr_err_in),
        .proc_gnt_out(proc_gnt_out), .wr_en_out(wr_en_out), .wr_sel_out(wr_sel_out),
        .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .busy_out(busy_out),
        .overrun_err_out(overrun_err_out), .select_err_out(select_err_out)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: frame collection, pending slot, write port and sticky flags.
    bit mInFrame, mTgt, mPend, mPendSel, mWrEn, mWrSel, mOvr, mSelErr;
    int mBits, mFrame, mPendAddr, mPendData, mWait, mWrAddr, mWrData;

    logic [12:0] obsWr[$];
    logic        obsGnt, obsWrEn;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mInFrame = 0; mTgt = 0; mBits = 0; mFrame = 0;
        mPend = 0; mPendSel = 0; mPendAddr = 0; mPendData = 0; mWait = 0;
        mWrEn = 0; mWrSel = 0; mWrAddr = 0; mWrData = 0;
        mOvr = 0; mSelErr = 0;
    endtask

    task automatic modelStep();
        bit oneLow, bothLow, take, done, issue, ovrEvt;
        int newFrame;
        if (rst) begin
            modelReset();
            return;
        end
        oneLow  = (csi_n != csd_n);
        bothLow = !csi_n && !csd_n;
        take    = mInFrame ? (oneLow && (mTgt ? !csd_n : !csi_n)) : oneLow;
        done = 0; newFrame = 0; ovrEvt = 0;
        if (take) begin
            mInFrame = 1;
            mTgt = !csd_n;
            if (bit_en_in) begin
                mFrame += int'(mosi_in) << mBits;
                mBits++;
                if (mBits == FW) begin
                    done = 1; newFrame = mFrame; mBits = 0; mFrame = 0;
                end
            end
        end else begin
            mInFrame = 0; mBits = 0; mFrame = 0;
        end
        issue = mPend && (!proc_req_in || mWait == MW);
        mWrEn = issue;
        if (issue) begin
            mWrSel = mPendSel; mWrAddr = mPendAddr; mWrData = mPendData;
            mWait = 0;
            mPend = done;
        end else if (mPend) begin
            if (mWait < MW) mWait++;
            ovrEvt = done;
        end else begin
            mPend = done;
        end
        if (done && !ovrEvt) begin
            mPendSel  = mTgt;
            mPendAddr = newFrame % (1 << AW);
            mPendData = (newFrame >> AW) % (1 << DW);
        end
        if (ovrEvt) mOvr = 1;
        else if (clr_err_in) mOvr = 0;
        if (bothLow) mSelErr = 1;
        else if (clr_err_in) mSelErr = 0;
    endtask

    task automatic checkAll();
        bit expGnt, expBusy;
        expGnt  = proc_req_in && !mWrEn && !(mPend && mWait == MW);
        expBusy = (mInFrame && mBits > 0) || mPend;
        obsGnt  = proc_gnt_out;
        obsWrEn = wr_en_out;
        if (wr_en_out === 1'b1) obsWr.push_back({wr_sel_out, wr_data_out, wr_addr_out});
        checkOutput("proc_gnt", 32'(proc_gnt_out), 32'(expGnt));
        checkOutput("wr_en", 32'(wr_en_out), 32'(mWrEn));
        checkOutput("wr_sel", 32'(wr_sel_out), 32'(mWrSel));
        checkOutput("wr_addr", 32'(wr_addr_out), 32'(mWrAddr));
        checkOutput("wr_data", 32'(wr_data_out), 32'(mWrData));
        checkOutput("busy", 32'(busy_out), 32'(expBusy));
        checkOutput("overrun_err", 32'(overrun_err_out), 32'(mOvr));
        checkOutput("select_err", 32'(select_err_out), 32'(mSelErr));
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model, cross the edge.
    task automatic applyStimulus(input logic csiN, input logic csdN, input logic mosi, input logic bitEn,
                                 input logic procReq, input logic clrErr, input logic rstIn);
        csi_n = csiN; csd_n = csdN; mosi_in = mosi; bit_en_in = bitEn;
        proc_req_in = procReq; clr_err_in = clrErr; rst = rstIn;
        #4;
        checkAll();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic procReq);
        for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 0, procReq, 0, 0);
    endtask

    // Sends addr/data LSB-first on the chosen select, after some select-low cycles with no bit strobe.
    task automatic sendFrame(input logic sel, input int addr, input int data, input logic procReq, input int gap);
        int f;
        f = (data << AW) | addr;
        for (int i = 0; i < gap; i++) applyStimulus(sel, !sel, 0, 0, procReq, 0, 0);
        for (int i = 0; i < FW; i++) applyStimulus(sel, !sel, 1'((f >> i) & 1), 1, procReq, 0, 0);
    endtask

    task automatic expectWrite(input string tag, input logic [12:0] expected);
        logic [12:0] got;
        got = (obsWr.size() > 0) ? obsWr.pop_front() : 13'h1FFF;
        checkOutput(tag, 32'(got), 32'(expected));
    endtask

    initial begin
        int gntHigh, holdLeft, mode, procPct;
        bit seenWr;
        logic cN, dN;

        rst = 1; csi_n = 1; csd_n = 1; mosi_in = 0; bit_en_in = 0; proc_req_in = 0; clr_err_in = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("reset_wr_en", 32'(wr_en_out), 0);
        checkOutput("reset_busy", 32'(busy_out), 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);

        // Uncontested icache write.
        obsWr.delete();
        sendFrame(0, 4'h5, 8'hA3, 0, 0);
        idle(5, 0);
        expectWrite("t1_write", {1'b0, 8'hA3, 4'h5});
        checkOutput("t1_count", 32'(obsWr.size()), 0);
        checkOutput("t1_busy_idle", 32'(busy_out), 0);

        // Starvation guard forces a dcache write past a continuously requesting processor.
        obsWr.delete();
        sendFrame(1, 4'hF, 8'h80, 1, 0);
        gntHigh = 0; seenWr = 0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1, 1, 0, 0, 1, 0, 0);
            if (obsWrEn) seenWr = 1;
            else if (!seenWr && obsGnt) gntHigh++;
        end
        idle(2, 0);
        checkOutput("t2_gnt_cycles", 32'(gntHigh), 15);
        checkOutput("t2_wr_seen", 32'(seenWr), 1);
        expectWrite("t2_write", {1'b1, 8'h80, 4'hF});

        // Back-to-back frames while the first is still blocked: second is dropped.
        obsWr.delete();
        sendFrame(0, 4'h1, 8'h11, 1, 0);
        sendFrame(0, 4'h2, 8'h22, 1, 0);
        idle(20, 1);
        idle(3, 0);
        expectWrite("t3_write", {1'b0, 8'h11, 4'h1});
        checkOutput("t3_extra", 32'(obsWr.size()), 0);
        checkOutput("t3_overrun", 32'(overrun_err_out), 1);
        applyStimulus(1, 1, 0, 0, 0, 1, 0);
        checkOutput("t3_overrun_clr", 32'(overrun_err_out), 0);

        // Second frame completes exactly when the guard forces out the first.
        obsWr.delete();
        sendFrame(0, 4'h4, 8'h5A, 1, 0);
        sendFrame(0, 4'h6, 8'h6B, 1, 4);
        idle(5, 0);
        expectWrite("t4_first", {1'b0, 8'h5A, 4'h4});
        expectWrite("t4_second", {1'b0, 8'h6B, 4'h6});
        checkOutput("t4_overrun", 32'(overrun_err_out), 0);

        // Partial frame aborted by select release leaves no residue.
        obsWr.delete();
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 1, 0, 0, 0);
        idle(1, 0);
        sendFrame(0, 4'h3, 8'h44, 0, 0);
        idle(4, 0);
        expectWrite("t5_write", {1'b0, 8'h44, 4'h3});
        checkOutput("t5_count", 32'(obsWr.size()), 0);

        // Both selects low, then reset with a frame pending.
        obsWr.delete();
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        idle(2, 0);
        checkOutput("t6_select_err", 32'(select_err_out), 1);
        checkOutput("t6_no_write", 32'(obsWr.size()), 0);
        sendFrame(0, 4'h7, 8'h77, 1, 0);
        idle(2, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        checkOutput("t6_rst_wr_en", 32'(wr_en_out), 0);
        checkOutput("t6_rst_busy", 32'(busy_out), 0);
        checkOutput("t6_rst_select_err", 32'(select_err_out), 0);
        idle(3, 0);
        checkOutput("t6_rst_no_write", 32'(obsWr.size()), 0);

        // Random traffic: held select stretches, bursty bit strobes, varying processor load.
        holdLeft = 0; mode = 0; procPct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) procPct = ($urandom_range(0, 3) == 0) ? 100 : 30 * int'($urandom_range(0, 3));
            if (holdLeft == 0) begin
                mode = int'($urandom_range(0, 99));
                mode = (mode < 6) ? 3 : (mode < 30) ? 0 : (mode < 65) ? 1 : 2;
                holdLeft = (mode == 3) ? int'($urandom_range(1, 3)) : int'($urandom_range(3, 40));
            end
            holdLeft--;
            cN = !(mode == 1 || mode == 3);
            dN = !(mode == 2 || mode == 3);
            applyStimulus(cN, dN, 1'($urandom), $urandom_range(0, 3) != 0,
                          int'($urandom_range(0, 99)) < procPct,
                          $urandom_range(0, 49) == 0, $urandom_range(0, 599) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_arbiter.md
Name: load_arbiter

Overview:
Serial-load controller and cache write-port arbiter that sits between the external SPI-style master interface (csi/csd/mosi) and the icache/dcache write ports.
- Assembles LSB-first frames (address then data) and holds each completed frame in a one-entry pending buffer.
- Issues single-cycle cache writes, arbitrating against processor-side cache use; the processor normally has priority, with a starvation guard.
- Replaces the free-running shift register plus ad-hoc write enables with a counted, framed, error-checked loader.

Parameters:
ADDR_W, 4, cache address width (frame bits [ADDR_W-1:0])
DATA_W, 8, cache data width (frame bits [ADDR_W+DATA_W-1:ADDR_W])
MAX_WAIT, 15, max cycles a pending frame may be blocked before the loader forces one write slot (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
csi_n  input  1  instruction-cache select, active low
csd_n  input  1  data-cache select, active low
mosi_in  input  1  serial data, sampled on clk when bit_en_in=1 and exactly one select is low
bit_en_in  input  1  bit-valid strobe
proc_req_in  input  1  processor requests cache port this cycle
clr_err_in  input  1  clears sticky error flags
proc_gnt_out  output  1  processor owns cache port this cycle
wr_en_out  output  1  registered one-cycle cache write strobe
wr_sel_out  output  1  0=icache, 1=dcache (valid with wr_en_out)
wr_addr_out  output  ADDR_W  write address
wr_data_out  output  DATA_W  write data
busy_out  output  1  frame in progress or pending
overrun_err_out  output  1  sticky: completed frame dropped
select_err_out  output  1  sticky: csi_n and csd_n both low seen

Behaviour:
Reset (synchronous): shift register, bit counter, pending buffer, wait counter and all outputs cleared to 0; FSM goes to IDLE. Reset mid-frame or with a frame pending discards it, and no write is issued.

Frame FSM, states IDLE, SHIFT:
- IDLE -> SHIFT: exactly one select low; latch target (csd_n low -> sel=1). If the first bit_en_in arrives in this same cycle, it is counted.
- SHIFT: each cycle with bit_en_in=1, shift mosi_in into MSB and shift right; count++. The first bit received ends at bit 0.
- Frame complete: the cycle in which the (ADDR_W+DATA_W)th bit is sampled (count 11 -> done for defaults). The assembled frame {sel, data, addr} is loaded into the pending buffer at that edge. The counter resets, the FSM stays in SHIFT while the same select stays low, so back-to-back frames are allowed.
- Select released (high) before completion: partial frame discarded, counter cleared, -> IDLE. Released after completion: -> IDLE.
- Both selects low: set select_err_out, discard the partial frame, -> IDLE, and stay there until at most one select is low.
- Target change mid-frame (switch from one select to the other without passing through both-high) is treated as a release.

Pending buffer and arbitration:
- Issue condition: pend=1 and (proc_req_in=0 or wait_cnt==MAX_WAIT).
- On issue, at the next edge: wr_en_out=1 for exactly one cycle, with wr_sel/addr/data from the buffer; pend clears; wait_cnt clears.
- While pend=1 and the write is not issued, wait_cnt increments, saturating at MAX_WAIT.
- proc_gnt_out = proc_req_in & ~wr_en_out & ~(pend & wait_cnt==MAX_WAIT). It is combinational and never high in a cycle where wr_en_out=1.
- Frame completes while pend=1 and not issuing that cycle: the new frame is dropped, the pending frame is kept, overrun_err_out is set.
- Frame completes in the same cycle a pending write issues: the new frame is accepted into the buffer, with no overrun.
- wr_addr/data/sel hold their last values when wr_en_out=0.
- busy_out = (state==SHIFT with count>0) | pend.
- clr_err_in clears both sticky errors. If an error event and clr_err_in occur in the same cycle, the event wins.

Latency: frame completion to wr_en_out is 2 cycles minimum (the buffer loads at the completion edge, and the write issues on the following edge when uncontested).

Test Plan:
- csi_n=0, 12 bits LSB-first encoding addr=0x5, data=0xA3, proc_req_in=0 -> two cycles after the last bit, wr_en_out=1 for 1 cycle, wr_sel=0, wr_addr=0x5, wr_data=0xA3; busy_out then returns to 0.
- csd_n=0, frame addr=0xF data=0x80 with proc_req_in held 1 -> proc_gnt_out=1 for 15 pending cycles, then proc_gnt_out=0 for one cycle, wr_en_out=1 with wr_sel=1, then proc_gnt_out=1 again.
- Two back-to-back csi frames (addr 1/0x11, addr 2/0x22) with proc_req_in=1 throughout the second frame -> second frame dropped, overrun_err_out=1, only the 0x11 write occurs; clr_err_in pulse clears the flag.
- Second frame completes in the exact cycle the first write issues -> both writes occur in order, overrun_err_out stays 0.
- csi_n released after 7 bits, then a full frame addr=0x3 data=0x44 -> a single write of 0x44 to 0x3, with no stale bits.
- csi_n and csd_n both low for 2 cycles -> select_err_out=1, no write. rst asserted with a frame pending -> no wr_en_out, and all outputs 0 the next cycle.
